// File: rtl/ik_swift_pkg.sv
// Shared definitions for the IK Swift iteration controller.
//   - DH field indices inside one joint's 4-word parameter set
//   - joint type encodings
//   - controller state encoding
//   - saturating add / saturating magnitude helpers
// The helpers work on a wide signed carrier (SAT_MAXW bits) and take the
// real word width w as an argument. Callers sign-extend a W-bit value into
// the carrier and truncate the result back to W bits. With w fixed by a
// module parameter, the range limits reduce to constants.
package ik_swift_pkg;

  localparam int DH_THETA  = 0;
  localparam int DH_D      = 1;
  localparam int DH_A      = 2;
  localparam int DH_ALPHA  = 3;
  localparam int DH_FIELDS = 4;

  localparam logic JT_REVOLUTE  = 1'b0;
  localparam logic JT_PRISMATIC = 1'b1;

  // Carrier width for the saturation helpers; must exceed any W in use.
  localparam int SAT_MAXW = 128;

  typedef logic signed [SAT_MAXW-1:0] sat_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_WAIT,
    ST_UPDATE,
    ST_FIN
  } ik_iter_state_t;

  // Largest value of a w-bit two's complement word: 2^(w-1)-1.
  function automatic sat_word_t sat_max(input int unsigned w);
    sat_word_t one;
    one = sat_word_t'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  // Smallest value of a w-bit two's complement word: -2^(w-1).
  function automatic sat_word_t sat_min(input int unsigned w);
    return -sat_max(w) - sat_word_t'(1);
  endfunction

  // Signed add clamped to the w-bit range. The carrier is wide enough that
  // the raw sum of two sign-extended w-bit values never wraps.
  function automatic sat_word_t sat_add(input sat_word_t a,
                                        input sat_word_t b,
                                        input int unsigned w);
    sat_word_t s;
    sat_word_t r;
    s = a + b;
    if (s > sat_max(w)) begin
      r = sat_max(w);
    end else if (s < sat_min(w)) begin
      r = sat_min(w);
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Magnitude of a w-bit value; the most negative value maps to 2^(w-1)-1
  // so the result always fits the positive w-bit range.
  function automatic sat_word_t sat_abs(input sat_word_t a,
                                        input int unsigned w);
    sat_word_t m;
    m = a[SAT_MAXW-1] ? -a : a;
    if (m > sat_max(w)) begin
      m = sat_max(w);
    end
    return m;
  endfunction

endpackage

// File: rtl/ik_swift_dh_update.sv
// One joint's DH parameter update, purely combinational.
// Ports:
//   dh_in  : the joint's 4 DH words, field f at [f*W +: W]
//   jtype  : 0 = revolute (delta goes to theta), 1 = prismatic (delta to d)
//   delta  : signed joint delta from the core
//   tol    : unsigned convergence tolerance
//   dh_out : dh_in with the selected field replaced by its saturated sum
//   conv   : |delta| <= tol (unsigned compare, saturated magnitude)
module ik_swift_dh_update
  import ik_swift_pkg::*;
#(
  parameter int W = 36
) (
  input  logic [DH_FIELDS*W-1:0] dh_in,
  input  logic                   jtype,
  input  logic signed [W-1:0]    delta,
  input  logic [W-1:0]           tol,
  output logic [DH_FIELDS*W-1:0] dh_out,
  output logic                   conv
);

  logic signed [W-1:0] field_cur;
  logic signed [W-1:0] field_sum;
  sat_word_t           delta_mag;
  sat_word_t           tol_wide;

  always_comb begin
    dh_out    = dh_in;
    field_cur = (jtype == JT_PRISMATIC) ? dh_in[DH_D*W +: W]
                                        : dh_in[DH_THETA*W +: W];
    field_sum = W'(sat_add(sat_word_t'(field_cur), sat_word_t'(delta), W));
    if (jtype == JT_PRISMATIC) begin
      dh_out[DH_D*W +: W] = field_sum;
    end else begin
      dh_out[DH_THETA*W +: W] = field_sum;
    end

    // Both operands are non-negative in the wide carrier, so the signed
    // compare behaves as the unsigned magnitude compare.
    delta_mag = sat_abs(sat_word_t'(delta), W);
    tol_wide  = sat_word_t'(tol);
    conv      = (delta_mag <= tol_wide);
  end

endmodule

// File: rtl/ik_swift_iter_ctrl.sv
// Iteration controller for the IK Swift core.
// Loads initial DH parameters on start, then loops: reset the core (KICK),
// enable it until it reports done or the watchdog expires (WAIT), apply the
// returned per-joint deltas with saturation (UPDATE). Stops on convergence
// (every |delta| <= tol), after MAX_ITER iterations, or on a core timeout,
// and pulses done for one cycle (FIN).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin a solve (only honoured in IDLE)
//   tol           : unsigned tolerance, latched on start
//   joint_type    : per-joint 0 = revolute, 1 = prismatic, latched on start
//   dh_param_in   : initial DH params, joint j field f at [(j*4+f)*W +: W]
//   busy          : high in every state except IDLE
//   done          : one-cycle pulse at the end of a solve
//   converged     : solve ended by convergence (held until next start)
//   timeout       : solve ended by the core watchdog (held until next start)
//   iter_count    : completed iterations (held until next start)
//   dh_param_out  : current DH params, also feeds the core
//   core_en       : core enable (high throughout WAIT)
//   core_rst      : core reset (reset input OR KICK state)
//   core_done     : core finished this run
//   core_delta    : signed per-joint deltas, valid with core_done
module ik_swift_iter_ctrl
  import ik_swift_pkg::*;
#(
  parameter int NJ          = 6,
  parameter int W           = 36,
  parameter int MAX_ITER    = 64,
  parameter int ITER_W      = $clog2(MAX_ITER + 1),
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [W-1:0]                tol,
  input  logic [NJ-1:0]               joint_type,
  input  logic [NJ*DH_FIELDS*W-1:0]   dh_param_in,
  output logic                        busy,
  output logic                        done,
  output logic                        converged,
  output logic                        timeout,
  output logic [ITER_W-1:0]           iter_count,
  output logic [NJ*DH_FIELDS*W-1:0]   dh_param_out,
  output logic                        core_en,
  output logic                        core_rst,
  input  logic                        core_done,
  input  logic [NJ*W-1:0]             core_delta
);

  localparam int JW = DH_FIELDS * W;

  ik_iter_state_t      state;
  logic [TO_W-1:0]     wd_cnt;

  // Solve operands latched at start / core completion; never reset, they
  // are only consumed after being written in the same solve.
  logic [W-1:0]        tol_q;
  logic [NJ-1:0]       jt_q;
  logic [NJ*W-1:0]     delta_q;

  logic [NJ*JW-1:0]    dh_upd;
  logic [NJ-1:0]       conv_vec;

  // The core is held in reset for the whole controller reset and for the
  // single KICK cycle that starts each run.
  assign core_rst = rst | (state == ST_KICK);

  for (genvar j = 0; j < NJ; j++) begin : g_joint
    ik_swift_dh_update #(
      .W(W)
    ) u_dh_update (
      .dh_in  (dh_param_out[j*JW +: JW]),
      .jtype  (jt_q[j]),
      .delta  (delta_q[j*W +: W]),
      .tol    (tol_q),
      .dh_out (dh_upd[j*JW +: JW]),
      .conv   (conv_vec[j])
    );
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      tol_q <= tol;
      jt_q  <= joint_type;
    end
    if (state == ST_WAIT && core_done) begin
      delta_q <= core_delta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      converged    <= 1'b0;
      timeout      <= 1'b0;
      core_en      <= 1'b0;
      iter_count   <= '0;
      wd_cnt       <= '0;
      dh_param_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_KICK;
            busy         <= 1'b1;
            dh_param_out <= dh_param_in;
            iter_count   <= '0;
            converged    <= 1'b0;
            timeout      <= 1'b0;
          end
        end

        ST_KICK: begin
          wd_cnt  <= '0;
          core_en <= 1'b1;
          state   <= ST_WAIT;
        end

        // core_done takes priority over a watchdog expiry in the same cycle.
        ST_WAIT: begin
          if (core_done) begin
            core_en <= 1'b0;
            state   <= ST_UPDATE;
          end else if (wd_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            core_en <= 1'b0;
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= ST_FIN;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end

        // Deltas are applied even on the iteration that converges.
        ST_UPDATE: begin
          dh_param_out <= dh_upd;
          iter_count   <= iter_count + ITER_W'(1);
          if (&conv_vec) begin
            converged <= 1'b1;
            done      <= 1'b1;
            state     <= ST_FIN;
          end else if (iter_count == ITER_W'(MAX_ITER - 1)) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            state <= ST_KICK;
          end
        end

        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
